// File: rtl/uart_rx_engine_pkg.sv
// Shared types and constants for the UART receive engine.
// Provides the FSM state type, parity codes, status bit positions and the parity helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_ODD   = 3'd1,
    PAR_EVEN  = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_t;

  // Status bit positions inside the 3-bit {brk,ferr,perr} field above the data
  localparam int ST_PERR = 0;
  localparam int ST_FERR = 1;
  localparam int ST_BRK  = 2;

  // Undefined codes fall through to the space rule
  function automatic logic par_expected(input logic [2:0] mode, input logic dataXor);
    case (mode)
      PAR_ODD:  return ~dataXor;
      PAR_EVEN: return dataXor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Receive-FIFO read port of the UART receive engine.
// master = engine side (presents head entry), slave = consumer side (issues pops).
interface uart_rx_engine_if #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 64
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                rd_i;
  logic [DATA_W+2:0]   data_o;
  logic                empty_o;
  logic                full_o;
  logic [LVL_W-1:0]    level_o;

  modport master (
    input  rd_i,
    output data_o,
    output empty_o,
    output full_o,
    output level_o
  );

  modport slave (
    output rd_i,
    input  data_o,
    input  empty_o,
    input  full_o,
    input  level_o
  );
endinterface

// File: rtl/uart_rx_engine_fifo.sv
// Synchronous first-word-fall-through FIFO for received characters.
// A write into a full FIFO is accepted only when a pop happens in the same clock; otherwise o_drop pulses.
module uart_rx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [AW:0]      w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_doWr;
  logic             w_doRd;

  assign w_level = r_wrPtr - r_rdPtr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_doRd  = i_rd && !w_empty;
  assign w_doWr  = i_wr && (!w_full || i_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doWr) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doRd) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doWr) r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
  end

  // Head is forced to zero while empty so the output is defined straight out of reset
  assign o_rdata = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = w_level;
  assign o_drop  = i_wr && w_full && !i_rd;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-FF synchroniser, oversampling deframer FSM, error counters and receive FIFO.
// Defining UART_RX_TIMEOUT_EN builds the idle-timeout counter behind rx_timeout_o.
module uart_rx_engine
  import uart_rx_pkg::*;
#(
  parameter int OVS        = 16,
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 64,
  parameter int TO_BITS    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acq_i,
  input  logic              rx_i,
  input  logic [3:0]        char_len_i,
  input  logic [2:0]        parity_i,
  input  logic              stop2_i,
  input  logic              msb_first_i,
  uart_rx_engine_if.master  fifo_if,
  output logic [7:0]        perr_cnt_o,
  output logic [7:0]        ferr_cnt_o,
  output logic [7:0]        ovr_cnt_o,
  output logic              rx_timeout_o
);
  localparam int PH_W  = $clog2(OVS);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = DATA_W + 3;

  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVS/2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVS/2);
  localparam logic [PH_W-1:0] PH_S2   = PH_W'(OVS/2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [3:0]      LEN_MIN = 4'd5;
  localparam logic [3:0]      LEN_MAX = 4'(DATA_W);

  logic              r_rxSync1;
  logic              r_rxSync2;
  logic              r_rxPrev;
  rx_state_t         r_state;
  logic [PH_W-1:0]   r_phase;
  logic [1:0]        r_samp;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_bitCnt;
  logic [3:0]        r_len;
  logic [2:0]        r_par;
  logic              r_stop2;
  logic              r_msbFirst;
  logic              r_perr;
  logic              r_ferr;
  logic              r_parBit;
  logic              r_stopIdx;
  logic              r_wr;
  logic [ENT_W-1:0]  r_wrData;
  logic [7:0]        r_perrCnt;
  logic [7:0]        r_ferrCnt;
  logic [7:0]        r_ovrCnt;

  rx_state_t         w_stateNxt;
  logic [PH_W-1:0]   w_phaseNxt;
  logic [1:0]        w_sampNxt;
  logic [DATA_W-1:0] w_shiftNxt;
  logic [3:0]        w_bitCntNxt;
  logic [3:0]        w_lenNxt;
  logic [2:0]        w_parNxt;
  logic              w_stop2Nxt;
  logic              w_msbNxt;
  logic              w_perrNxt;
  logic              w_ferrNxt;
  logic              w_parBitNxt;
  logic              w_stopIdxNxt;
  logic              w_wrNxt;
  logic [ENT_W-1:0]  w_wrDataNxt;

  logic              w_fall;
  logic              w_decide;
  logic              w_maj;
  logic              w_ferrFinal;
  logic              w_brk;
  logic [3:0]        w_lenClamp;
  logic [DATA_W-1:0] w_data;
  logic [ENT_W-1:0]  w_fifoData;
  logic              w_empty;
  logic              w_full;
  logic [LVL_W-1:0]  w_level;
  logic              w_drop;

  // Synchroniser and edge-history flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxSync1 <= rx_i;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
    end
  end

  assign w_fall      = r_rxPrev && !r_rxSync2;
  assign w_decide    = acq_i && (r_phase == PH_S2);
  assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rxSync2) | (r_samp[1] & r_rxSync2);
  assign w_ferrFinal = r_ferr | ~w_maj;
  assign w_data      = r_msbFirst ? r_shift : (r_shift >> (LEN_MAX - r_len));
  assign w_brk       = w_ferrFinal && (w_data == '0) && !r_parBit;
  assign w_lenClamp  = (char_len_i < LEN_MIN) ? LEN_MIN :
                       (char_len_i > LEN_MAX) ? LEN_MAX : char_len_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_samp     <= 2'b11;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_len      <= 4'd8;
      r_par      <= 3'd0;
      r_stop2    <= 1'b0;
      r_msbFirst <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_parBit   <= 1'b0;
      r_stopIdx  <= 1'b0;
      r_wr       <= 1'b0;
      r_wrData   <= '0;
    end else begin
      r_state    <= w_stateNxt;
      r_phase    <= w_phaseNxt;
      r_samp     <= w_sampNxt;
      r_shift    <= w_shiftNxt;
      r_bitCnt   <= w_bitCntNxt;
      r_len      <= w_lenNxt;
      r_par      <= w_parNxt;
      r_stop2    <= w_stop2Nxt;
      r_msbFirst <= w_msbNxt;
      r_perr     <= w_perrNxt;
      r_ferr     <= w_ferrNxt;
      r_parBit   <= w_parBitNxt;
      r_stopIdx  <= w_stopIdxNxt;
      r_wr       <= w_wrNxt;
      r_wrData   <= w_wrDataNxt;
    end
  end

  // Every state acts at its majority decision, so the phase counter runs freely across the frame
  always_comb begin
    w_stateNxt   = r_state;
    w_phaseNxt   = r_phase;
    w_sampNxt    = r_samp;
    w_shiftNxt   = r_shift;
    w_bitCntNxt  = r_bitCnt;
    w_lenNxt     = r_len;
    w_parNxt     = r_par;
    w_stop2Nxt   = r_stop2;
    w_msbNxt     = r_msbFirst;
    w_perrNxt    = r_perr;
    w_ferrNxt    = r_ferr;
    w_parBitNxt  = r_parBit;
    w_stopIdxNxt = r_stopIdx;
    w_wrNxt      = 1'b0;
    w_wrDataNxt  = r_wrData;

    if (acq_i) begin
      w_phaseNxt = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      if (r_phase == PH_S0) w_sampNxt[0] = r_rxSync2;
      if (r_phase == PH_S1) w_sampNxt[1] = r_rxSync2;
    end

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_stateNxt = START;
          w_phaseNxt = '0;
        end
      end
      START: begin
        if (w_decide) begin
          if (w_maj) begin
            w_stateNxt = IDLE;
          end else begin
            w_stateNxt   = DATA;
            w_lenNxt     = w_lenClamp;
            w_parNxt     = parity_i;
            w_stop2Nxt   = stop2_i;
            w_msbNxt     = msb_first_i;
            w_shiftNxt   = '0;
            w_bitCntNxt  = '0;
            w_perrNxt    = 1'b0;
            w_ferrNxt    = 1'b0;
            w_parBitNxt  = 1'b0;
            w_stopIdxNxt = 1'b0;
          end
        end
      end
      DATA: begin
        if (w_decide) begin
          w_shiftNxt  = r_msbFirst ? {r_shift[DATA_W-2:0], w_maj} : {w_maj, r_shift[DATA_W-1:1]};
          w_bitCntNxt = r_bitCnt + 1'b1;
          if (r_bitCnt == r_len - 4'd1) begin
            w_stateNxt = (r_par != 3'(PAR_NONE)) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_decide) begin
          w_parBitNxt = w_maj;
          w_perrNxt   = (w_maj != par_expected(r_par, ^r_shift));
          w_stateNxt  = STOP;
        end
      end
      STOP: begin
        if (w_decide) begin
          w_ferrNxt = w_ferrFinal;
          if (r_stop2 && !r_stopIdx) begin
            w_stopIdxNxt = 1'b1;
          end else begin
            w_wrNxt                     = 1'b1;
            w_wrDataNxt[DATA_W-1:0]     = w_data;
            w_wrDataNxt[DATA_W+ST_PERR] = r_perr;
            w_wrDataNxt[DATA_W+ST_FERR] = w_ferrFinal;
            w_wrDataNxt[DATA_W+ST_BRK]  = w_brk;
            w_stateNxt                  = w_brk ? BRKWAIT : IDLE;
            w_phaseNxt                  = '0;
          end
        end
      end
      BRKWAIT: begin
        // Phase counts consecutive high samples; any low sample restarts the bit-time
        if (acq_i) begin
          if (!r_rxSync2) begin
            w_phaseNxt = '0;
          end else if (r_phase == PH_LAST) begin
            w_stateNxt = IDLE;
          end
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  // Error counters saturate; perr/ferr count on every completed frame, dropped or not
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perrCnt <= '0;
      r_ferrCnt <= '0;
      r_ovrCnt  <= '0;
    end else begin
      if (r_wr && r_wrData[DATA_W+ST_PERR] && (r_perrCnt != 8'hFF)) r_perrCnt <= r_perrCnt + 8'd1;
      if (r_wr && r_wrData[DATA_W+ST_FERR] && (r_ferrCnt != 8'hFF)) r_ferrCnt <= r_ferrCnt + 8'd1;
      if (w_drop && (r_ovrCnt != 8'hFF)) r_ovrCnt <= r_ovrCnt + 8'd1;
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_wr),
    .i_wdata (r_wrData),
    .i_rd    (fifo_if.rd_i),
    .o_rdata (w_fifoData),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level),
    .o_drop  (w_drop)
  );

  assign fifo_if.data_o  = w_fifoData;
  assign fifo_if.empty_o = w_empty;
  assign fifo_if.full_o  = w_full;
  assign fifo_if.level_o = w_level;
  assign perr_cnt_o      = r_perrCnt;
  assign ferr_cnt_o      = r_ferrCnt;
  assign ovr_cnt_o       = r_ovrCnt;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_BITS + 1);

  logic [PH_W-1:0] r_toPhase;
  logic [TO_W-1:0] r_toBits;
  logic            r_timeout;
  logic            w_toClear;

  assign w_toClear = fifo_if.rd_i || w_empty || ((r_state == IDLE) && w_fall);

  // Bit-times are counted only while idle with unread data waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_toPhase <= '0;
      r_toBits  <= '0;
      r_timeout <= 1'b0;
    end else if (w_toClear) begin
      r_toPhase <= '0;
      r_toBits  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_toBits == TO_W'(TO_BITS)) r_timeout <= 1'b1;
      if ((r_state == IDLE) && acq_i) begin
        if (r_toPhase == PH_LAST) begin
          r_toPhase <= '0;
          if (r_toBits != TO_W'(TO_BITS)) r_toBits <= r_toBits + 1'b1;
        end else begin
          r_toPhase <= r_toPhase + 1'b1;
        end
      end
    end
  end

  assign rx_timeout_o = r_timeout;
`else
  logic [31:0] w_unusedToBits;
  assign w_unusedToBits = TO_BITS;
  assign rx_timeout_o   = 1'b0;
`endif

endmodule
